// File: rtl/spm_mac_param_if.sv
// Operand/control and result bundle for the serial-parallel MAC engine.
// master drives operands and start; slave returns the product and status.
interface spm_mac_param_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     mc;
    logic [WIDTH-1:0]     mp;
    logic                 sgn;
    logic                 acc_en;
    logic [2*WIDTH-1:0]   prod;
    logic                 busy;
    logic                 done;
    logic                 ovf;

    modport master (
        output start, mc, mp, sgn, acc_en,
        input  prod, busy, done, ovf
    );

    modport slave (
        input  start, mc, mp, sgn, acc_en,
        output prod, busy, done, ovf
    );
endinterface

// File: rtl/spm_mac_param.sv
// Serial-parallel multiply-accumulate: one multiplier bit per cycle, WIDTH cycles of busy.
// start is accepted only in IDLE; requests during BUSY or on the completion edge are dropped.
module spm_mac_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    spm_mac_param_if.slave   bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mc_q;
    logic [WIDTH-1:0] mp_q;
    logic             sgn_q;
    logic             acc_en_q;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    prod_q;
    logic             done_q;
    logic             ovf_q;

    logic [PW-1:0]    mp_ext;
    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_nxt;
    logic [PW-1:0]    term;
    logic             last;
    logic             acc_ovf;

    always_comb begin
        mp_ext  = sgn_q ? {{WIDTH{mp_q[WIDTH-1]}}, mp_q} : {{WIDTH{1'b0}}, mp_q};
        addend  = mp_ext << cnt;
        last    = (cnt == CW'(WIDTH - 1));
        acc_nxt = acc;
        // The signed MSB of the multiplier carries negative weight.
        if (mc_q[cnt]) begin
            acc_nxt = (sgn_q && last) ? (acc - addend) : (acc + addend);
        end
        // prod holds the pre-accumulate value throughout BUSY, so the
        // difference recovers the exact product (it always fits PW bits).
        term    = acc_nxt - prod_q;
        if (sgn_q) begin
            acc_ovf = (term[PW-1] == prod_q[PW-1]) && (acc_nxt[PW-1] != prod_q[PW-1]);
        end else begin
            acc_ovf = (acc_nxt < prod_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mc_q     <= '0;
            mp_q     <= '0;
            sgn_q    <= 1'b0;
            acc_en_q <= 1'b0;
            acc      <= '0;
            prod_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                mc_q     <= bus.mc;
                mp_q     <= bus.mp;
                sgn_q    <= bus.sgn;
                acc_en_q <= bus.acc_en;
                acc      <= bus.acc_en ? prod_q : '0;
                cnt      <= '0;
                done_q   <= 1'b0;
                if (!bus.acc_en) begin
                    ovf_q <= 1'b0;
                end
                state    <= BUSY;
            end
        end else begin
            acc <= acc_nxt;
            if (last) begin
                prod_q <= acc_nxt;
                done_q <= 1'b1;
                state  <= IDLE;
                if (acc_en_q && acc_ovf) begin
                    ovf_q <= 1'b1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.prod = prod_q;
    assign bus.busy = (state == BUSY);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
endmodule
